// File: rtl/tortoise_pkg.sv
// Shared core types and sizing for the front end.
// The fetch queue pop width can be overridden by the build through CONFIG_FETCHQ_POP_WIDTH.
`ifndef CONFIG_FETCHQ_POP_WIDTH
`define CONFIG_FETCHQ_POP_WIDTH 1
`endif

package tortoise_pkg;

    localparam int IFQ_DEPTH        = 8;
    localparam int INSTR_PER_FETCH  = 2;
    localparam int FETCHQ_POP_WIDTH = `CONFIG_FETCHQ_POP_WIDTH;

    typedef struct packed {
        logic        is_taken;
        logic [31:0] target;
    } branch_predict_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] cause;
    } exception_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     pc;
        logic [31:0]     instr;
        branch_predict_t predict;
        exception_t      ex;
    } fetch_entry_t;

    // A kept lane that redirects or traps ends the fetch group; younger lanes are wrong-path.
    function automatic logic ends_group(fetch_entry_t e);
        return e.predict.is_taken | e.ex.valid;
    endfunction

endpackage

// File: rtl/fetch_lane_compact.sv
// Filters a fetch group (dropping lanes younger than a taken branch or exception)
// and packs the surviving lanes into the low slots in program order.
module fetch_lane_compact
    import tortoise_pkg::*;
#(
    parameter  int PUSH_WIDTH = INSTR_PER_FETCH,
    localparam int NW         = $clog2(PUSH_WIDTH + 1)
) (
    input  fetch_entry_t [PUSH_WIDTH-1:0] lanes_i,
    output fetch_entry_t [PUSH_WIDTH-1:0] lanes_o,
    output logic [NW-1:0]                 n_push_o
);

    logic [PUSH_WIDTH-1:0] kept;
    logic [NW-1:0]         pos [PUSH_WIDTH];
    logic [NW-1:0]         cnt;
    logic                  blocked;

    // pos[i] is the slot lane i lands in when kept (number of kept lanes below it).
    always_comb begin
        blocked = 1'b0;
        cnt     = '0;
        kept    = '0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            pos[i]  = cnt;
            kept[i] = lanes_i[i].valid & ~blocked;
            if (kept[i]) begin
                cnt     = cnt + NW'(1);
                blocked = blocked | ends_group(lanes_i[i]);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < PUSH_WIDTH; s++) begin
            lanes_o[s] = '0;
            for (int i = 0; i < PUSH_WIDTH; i++) begin
                if (kept[i] && pos[i] == NW'(s)) begin
                    lanes_o[s] = lanes_i[i];
                end
            end
        end
    end

    assign n_push_o = cnt;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: compacts fetch groups into a circular buffer and presents
// the oldest entries to decode. ready_o reserves room for a whole group regardless of pop.
module fetch_queue
    import tortoise_pkg::*;
#(
    parameter  int DEPTH      = IFQ_DEPTH,
    parameter  int PUSH_WIDTH = INSTR_PER_FETCH,
    parameter  int POP_WIDTH  = FETCHQ_POP_WIDTH,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int NW         = $clog2(PUSH_WIDTH + 1),
    localparam int PCW        = $clog2(POP_WIDTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  fetch_entry_t [PUSH_WIDTH-1:0] push_i,
    output logic                          ready_o,
    output fetch_entry_t [POP_WIDTH-1:0]  pop_data_o,
    output logic [POP_WIDTH-1:0]          pop_valid_o,
    input  logic [PCW-1:0]                pop_cnt_i,
    output logic [CW-1:0]                 count_o
);

    fetch_entry_t mem [DEPTH];

    logic [AW-1:0] rptr_reg, rptr_next;
    logic [AW-1:0] wptr_reg, wptr_next;
    logic [CW-1:0] count_reg, count_next;

    fetch_entry_t [PUSH_WIDTH-1:0] comp_lanes;
    logic [NW-1:0]                 n_push;
    logic                          push_en;
    logic [CW-1:0]                 push_n;
    logic [CW-1:0]                 pop_req;
    logic [CW-1:0]                 pop_eff;

    fetch_lane_compact #(
        .PUSH_WIDTH (PUSH_WIDTH)
    ) u_compact (
        .lanes_i  (push_i),
        .lanes_o  (comp_lanes),
        .n_push_o (n_push)
    );

    assign ready_o = (CW'(DEPTH) - count_reg) >= CW'(PUSH_WIDTH);
    assign push_en = ready_o & ~flush_i & (n_push != '0);
    assign push_n  = push_en ? CW'(n_push) : '0;

    // Over-consumption is a protocol error; clamp so occupancy can never underflow.
    assign pop_req = CW'(pop_cnt_i);
    assign pop_eff = (pop_req > count_reg) ? count_reg : pop_req;

    always_comb begin
        rptr_next  = rptr_reg;
        wptr_next  = wptr_reg;
        count_next = count_reg;
        if (flush_i) begin
            rptr_next  = '0;
            wptr_next  = '0;
            count_next = '0;
        end else begin
            rptr_next  = rptr_reg + AW'(pop_eff);
            wptr_next  = wptr_reg + AW'(push_n);
            count_next = count_reg + push_n - pop_eff;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            for (int s = 0; s < PUSH_WIDTH; s++) begin
                if (NW'(s) < n_push) begin
                    mem[wptr_reg + AW'(s)] <= comp_lanes[s];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < POP_WIDTH; gi++) begin : g_pop
            fetch_entry_t lane;
            assign pop_valid_o[gi] = CW'(gi) < count_reg;
            always_comb begin
                lane       = mem[rptr_reg + AW'(gi)];
                lane.valid = pop_valid_o[gi];
            end
            assign pop_data_o[gi] = lane;
        end
    endgenerate

    assign count_o = count_reg;

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !flush_i |-> (CW'(pop_cnt_i) <= count_reg));

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_reg <= CW'(DEPTH));

    a_hold_not_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (!ready_o && !flush_i) |=> (wptr_reg == $past(wptr_reg)));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: a queue-based reference model tracks expected contents,
// and a negedge monitor compares every presented output against it.
`timescale 1ns/1ps
module tb_fetch_queue;
    import tortoise_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 2;
    localparam int POPW  = 1;

    logic                    clk      = 1'b0;
    logic                    rst_n    = 1'b0;
    logic                    flush    = 1'b0;
    fetch_entry_t [PW-1:0]   push     = '0;
    logic                    ready;
    fetch_entry_t [POPW-1:0] pop_data;
    logic [POPW-1:0]         pop_valid;
    logic [0:0]              pop_cnt  = '0;
    logic [3:0]              count;

    fetch_queue #(
        .DEPTH      (DEPTH),
        .PUSH_WIDTH (PW),
        .POP_WIDTH  (POPW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .push_i      (push),
        .ready_o     (ready),
        .pop_data_o  (pop_data),
        .pop_valid_o (pop_valid),
        .pop_cnt_i   (pop_cnt),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    fetch_entry_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue contents in program order.
    always @(posedge clk or negedge rst_n) begin
        bit can_push;
        if (!rst_n) begin
            sb.delete();
        end else if (flush) begin
            sb.delete();
        end else begin
            can_push = (DEPTH - sb.size()) >= PW;
            for (int k = 0; k < int'(pop_cnt); k++) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (can_push) begin
                for (int i = 0; i < PW; i++) begin
                    if (push[i].valid) begin
                        sb.push_back(push[i]);
                        if (push[i].predict.is_taken || push[i].ex.valid) break;
                    end
                end
            end
        end
    end

    // Monitor: whatever the DUT presents must match the head of the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count", 128'(count), 128'(sb.size()));
            check("ready", 128'(ready), 128'((DEPTH - sb.size()) >= PW));
            check("pop_valid", 128'(pop_valid[0]), 128'(sb.size() > 0));
            if (sb.size() > 0) begin
                check("pop_data", 128'(pop_data[0]), 128'(sb[0]));
            end
        end
    end

    function automatic fetch_entry_t mk(logic [31:0] pc, bit taken, bit exc);
        fetch_entry_t e;
        e                = '0;
        e.valid          = 1'b1;
        e.pc             = pc;
        e.instr          = pc ^ 32'h0001_3579;
        e.predict.is_taken = taken;
        e.predict.target = pc + 32'd64;
        e.ex.valid       = exc;
        e.ex.cause       = exc ? 5'd2 : 5'd0;
        return e;
    endfunction

    function automatic fetch_entry_t rand_entry(int valid_pct);
        fetch_entry_t e;
        e.valid            = (int'($urandom_range(99)) < valid_pct);
        e.pc               = $urandom;
        e.instr            = $urandom;
        e.predict.is_taken = ($urandom_range(7) == 0);
        e.predict.target   = $urandom;
        e.ex.valid         = ($urandom_range(9) == 0);
        e.ex.cause         = 5'($urandom);
        return e;
    endfunction

    task automatic step(fetch_entry_t l0, fetch_entry_t l1, bit do_pop, bit do_flush);
        @(posedge clk);
        #2;
        push[0] = l0;
        push[1] = l1;
        pop_cnt = 1'(do_pop && sb.size() > 0);
        flush   = do_flush;
    endtask

    task automatic rand_step(int push_pct, int pop_pct, int flush_pct);
        @(posedge clk);
        #2;
        push[0] = rand_entry(push_pct);
        push[1] = rand_entry(push_pct);
        pop_cnt = 1'(sb.size() > 0 && int'($urandom_range(99)) < pop_pct);
        flush   = (int'($urandom_range(99)) < flush_pct);
    endtask

    fetch_entry_t inv;

    initial begin
        inv = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 128'(count), 128'(0));
        check("reset_ready", 128'(ready), 128'(1));
        check("reset_pop_valid", 128'(pop_valid), 128'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Basic push and pop
        step(mk(32'h100, 0, 0), mk(32'h104, 0, 0), 0, 0);
        step(inv, inv, 1, 0);
        step(inv, inv, 1, 0);
        // Taken branch drops the younger lane; then a hole is compacted
        step(mk(32'h200, 1, 0), mk(32'h204, 0, 0), 0, 0);
        step(inv, mk(32'h300, 0, 0), 0, 0);
        step(inv, inv, 1, 0);
        step(inv, inv, 1, 0);
        // Exception drops lane 1, entry pops with ex intact
        step(mk(32'h400, 0, 1), mk(32'h404, 0, 0), 0, 0);
        step(inv, inv, 1, 0);
        // Fill, hold while full, then drain to reopen
        for (int k = 0; k < 5; k++) step(mk(32'h500 + 32'(k * 8), 0, 0), mk(32'h504 + 32'(k * 8), 0, 0), 0, 0);
        step(inv, inv, 1, 0);
        step(inv, inv, 1, 0);
        step(inv, inv, 0, 0);
        // Flush wins over simultaneous push and pop
        step(mk(32'h600, 0, 0), mk(32'h604, 0, 0), 1, 1);
        step(inv, inv, 0, 0);
        // Walk pointers to 7, then a group straddles the wrap
        for (int k = 0; k < 7; k++) step(mk(32'h700 + 32'(k * 4), 0, 0), inv, 1, 0);
        step(inv, inv, 1, 0);
        step(mk(32'h800, 0, 0), mk(32'h804, 0, 0), 0, 0);
        step(inv, inv, 1, 0);
        step(inv, inv, 1, 0);
        step(inv, inv, 0, 0);

        for (int k = 0; k < 300; k++) rand_step(90, 20, 1);
        for (int k = 0; k < 300; k++) rand_step(50, 80, 2);

        // Asynchronous reset in the middle of traffic
        step(mk(32'h900, 0, 0), mk(32'h904, 0, 0), 0, 0);
        step(mk(32'h908, 0, 0), mk(32'h90c, 0, 0), 0, 0);
        @(posedge clk);
        #3;
        push    = '0;
        pop_cnt = '0;
        flush   = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midreset_count", 128'(count), 128'(0));
        check("midreset_ready", 128'(ready), 128'(1));
        check("midreset_pop_valid", 128'(pop_valid), 128'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 400; k++) rand_step(70, 50, 2);
        step(inv, inv, 0, 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
